// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: two half adders plus a registered carry,
// one bit per clock LSB-first, with a one-cycle done pulse.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] res;
    logic [CW-1:0]    cnt;
    logic             carry;

    logic             p;
    logic             g1;
    logic             s;
    logic             g2;
    logic             carry_next;
    logic [WIDTH-1:0] res_next;

    // Full-adder cell built from two half adders on the current LSBs
    always_comb begin
        p          = op_a[0] ^ op_b[0];
        g1         = op_a[0] & op_b[0];
        s          = p ^ carry;
        g2         = p & carry;
        carry_next = g1 | g2;
        res_next   = {s, res[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            op_a  <= '0;
            op_b  <= '0;
            res   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        op_a  <= a;
                        op_b  <= b;
                        carry <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    carry <= carry_next;
                    res   <= res_next;
                    op_a  <= op_a >> 1;
                    op_b  <= op_b >> 1;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        sum   <= res_next;
                        cout  <= carry_next;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: driver pushes expected {cout,sum},
// a negedge monitor pops and compares on every done pulse.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    logic [8:0] exp_q[$];
    int         tests = 0;
    int         fails = 0;
    int         starts = 0;
    int         done_cnt = 0;

    serial_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [8:0] act,
                         input logic [8:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Call at a negedge with the DUT idle; returns 1 time unit after edge 0
    task automatic issue(input logic [7:0] x, input logic [7:0] y);
        a = x;
        b = y;
        start = 1'b1;
        exp_q.push_back({1'b0, x} + {1'b0, y});
        starts++;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", {8'h0, busy}, 9'h0);
    endtask

    // Monitor / scoreboard
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: got %h, expected none",
                             {cout, sum});
                end else begin
                    e = exp_q.pop_front();
                    check("result", {cout, sum}, e);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {8'h0, busy}, 9'h0);
        check("rst_done", {8'h0, done}, 9'h0);
        check("rst_out", {cout, sum}, 9'h0);
        rst_n = 1'b1;

        // Latency and busy window
        issue(8'h00, 8'h00);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            check($sformatf("lat_busy_c%0d", k), {8'h0, busy},
                  {8'h0, (k <= 9)});
            check($sformatf("lat_done_c%0d", k), {8'h0, done},
                  {8'h0, (k == 9)});
        end

        issue(8'hFF, 8'h01);
        wait_idle();
        issue(8'hFF, 8'hFF);
        wait_idle();

        // Previous result held through RUN
        issue(8'hA5, 8'h5A);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check($sformatf("hold_c%0d", k), {cout, sum}, 9'h1FE);
        end
        wait_idle();

        // start held high, operands changed mid-RUN
        a = 8'h03;
        b = 8'h04;
        start = 1'b1;
        exp_q.push_back(9'h007);
        starts++;
        @(posedge clk);
        #1;
        a = 8'h11;
        b = 8'h22;
        exp_q.push_back(9'h033);
        starts++;
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("gap_busy", {8'h0, busy}, 9'h0);
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("restart_busy", {8'h0, busy}, 9'h1);
        wait_idle();

        // Reset at the 4th RUN edge aborts the add
        issue(8'h12, 8'h34);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        void'(exp_q.pop_back());
        starts--;
        @(negedge clk);
        check("abort_busy", {8'h0, busy}, 9'h0);
        check("abort_done", {8'h0, done}, 9'h0);
        check("abort_out", {cout, sum}, 9'h0);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) check("abort_nodone", 9'h1, 9'h0);
        end
        issue(8'h80, 8'h80);
        wait_idle();
        check("after_abort", {cout, sum}, 9'h100);

        // Random sweep
        for (int i = 0; i < 200; i++) begin
            issue(8'($urandom), 8'($urandom));
            wait_idle();
        end

        repeat (3) @(negedge clk);
        check("done_count", 9'(done_cnt), 9'(starts));
        check("queue_empty", 9'(exp_q.size()), 9'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
